ctrl_unit: RTL and testbench
============================

Name: ctrl_unit

Overview:
- Multicycle control FSM for the 32-bit datapath.
- Sequences fetch, decode, execute, memory and writeback.
- Drives every datapath select and write strobe, including S_MXSE, the ALU B-operand mux select (0 = sign-extended immediate, 1 = register B).
- Owns the memory request/ready handshake and a memory-wait timeout.

Parameters:
- MEM_TIMEOUT, 15: max consecutive wait cycles (REQ=1, RDY=0) before entering ERR; legal range 1..255.
- OPC_W, 4: opcode field width, taken from in_IR[31:28].

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_IR  in  32  instruction register contents (held by datapath after W_IR).
- in_Z  in  1  ALU zero flag, valid in EXEC.
- in_MEM_RDY  in  1  memory ready; completes the current request.
- S_MXSE  out  1  ALU B select: 0 = SE, 1 = RB.
- S_MXWB  out  1  writeback select: 0 = ALU result, 1 = memory data.
- S_PC  out  1  PC source: 0 = PC+4, 1 = branch/jump target.
- W_PC  out  1  PC write strobe.
- W_IR  out  1  IR write strobe.
- W_RF  out  1  register file write strobe.
- MEM_REQ  out  1  memory request.
- MEM_WE  out  1  memory write (valid only with MEM_REQ).
- ALU_OP  out  4  ALU function; in_IR[27:24] in EXEC, 4'h0 (ADD) otherwise.
- out_STATE  out  3  current state encoding, for debug.
- out_HALT  out  1  high while in HALT.
- out_ERR  out  1  high while in ERR.

Behaviour:
- Reset:
  - While reset=1 at a rising edge, state goes to FETCH and the wait counter clears.
  - During any cycle with reset=1, all outputs are forced to 0.
  - Reset mid-operation aborts the current instruction; no strobe is issued in that cycle.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERR=6. Encoding 7 is unreachable and recovers to ERR.
- Outputs are decoded combinationally from the state register and in_IR. Any strobe not listed for a state is 0.
- FETCH:
  - MEM_REQ=1, MEM_WE=0.
  - If in_MEM_RDY=1: W_IR=1, W_PC=1, S_PC=0, then go to DECODE. Otherwise stay.
- DECODE: 1 cycle, no strobes.
  - Opcode 0..5 goes to EXEC, 4'hF goes to HALT, any other opcode goes to ERR.
- EXEC, 1 cycle:
  - Opcode 0 (ALU reg-reg): S_MXSE=1, then WB.
  - Opcode 1 (ALU reg-imm): S_MXSE=0, then WB.
  - Opcode 2 (LOAD): S_MXSE=0 (address = RA + SE), then MEM.
  - Opcode 3 (STORE): S_MXSE=0, then MEM.
  - Opcode 4 (JUMP): W_PC=1, S_PC=1, then FETCH.
  - Opcode 5 (BEQ): S_MXSE=1 (compare RA - RB). If in_Z=1: W_PC=1, S_PC=1. Then FETCH.
- MEM:
  - MEM_REQ=1; MEM_WE=1 for STORE only. S_MXSE=0 is held so the address stays stable.
  - On in_MEM_RDY=1: LOAD goes to WB, STORE goes to FETCH.
- WB, 1 cycle: W_RF=1. S_MXWB=1 for LOAD, 0 for ALU ops. Then FETCH.
- HALT: out_HALT=1, no strobes, no MEM_REQ. Left only by reset.
- ERR: out_ERR=1, no strobes. Left only by reset.
- Wait counter (8-bit):
  - Increments each cycle in FETCH/MEM while in_MEM_RDY=0.
  - Clears on in_MEM_RDY=1 and on any state change.
  - When the counter equals MEM_TIMEOUT and in_MEM_RDY=0, the next state is ERR.
  - If in_MEM_RDY=1 arrives in that same cycle, ready wins and the normal transition is taken.
- Latency with zero-wait memory:
  - ALU instructions: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - JUMP/BEQ: 3 cycles.
  - Each memory wait cycle adds 1.

Decomposition:
- Shared package ctrl_pkg holds:
  - state encodings (ST_FETCH..ST_ERR);
  - opcode constants (OP_ALUR=0, OP_ALUI=1, OP_LD=2, OP_ST=3, OP_JMP=4, OP_BEQ=5, OP_HALT=4'hF);
  - MXSE_SE=0, MXSE_RB=1.
- One natural sub-module, ctrl_wait_cnt: the timeout counter, with inputs clear/enable and output expired.
- Next-state and output decode stay in ctrl_unit.

Test Plan:
- Reset: hold reset=1 for 2 cycles with in_MEM_RDY=1 → all outputs 0 and out_STATE=0; first cycle after release shows MEM_REQ=1.
- ALU imm vs reg: in_IR=32'h1300_0000, RDY tied 1 → EXEC shows S_MXSE=0 and ALU_OP=4'h3; WB shows W_RF=1, S_MXWB=0; total 4 cycles. Repeat with in_IR=32'h0300_0000 → S_MXSE=1 in EXEC.
- LOAD with 3 wait cycles in MEM: in_IR=32'h2000_0004 → MEM_REQ=1, MEM_WE=0 for 4 cycles; then WB with S_MXWB=1, W_RF=1.
- STORE: in_IR=32'h3000_0008 → MEM_WE=1 during MEM; no W_RF at any point.
- BEQ: in_IR=32'h5000_0010 with in_Z=1 → EXEC shows W_PC=1, S_PC=1. With in_Z=0 → W_PC=0 in EXEC.
- Timeout and terminal states:
  - RDY held 0 in FETCH for MEM_TIMEOUT+1 cycles → out_ERR=1 and stays 1 until reset.
  - in_IR=32'hF000_0000 → out_HALT=1.
  - in_IR=32'h7000_0000 → ERR.

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state, opcode and mux-select encodings for the multicycle control unit
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  localparam logic [3:0] OP_ALUR = 4'h0;
  localparam logic [3:0] OP_ALUI = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_BEQ  = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic MXSE_SE = 1'b0;
  localparam logic MXSE_RB = 1'b1;

  function automatic logic opc_exec_legal(input logic [3:0] opc);
    return opc <= OP_BEQ;
  endfunction

endpackage

// File: rtl/ctrl_wait_cnt.sv
// rtl/ctrl_wait_cnt.sv - memory-wait cycle counter that flags expiry at MEM_TIMEOUT
module ctrl_wait_cnt #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = 8'd0;
    end else if (en_i && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == 8'(MEM_TIMEOUT));

endmodule

// File: rtl/ctrl_unit.sv
// rtl/ctrl_unit.sv - multicycle fetch/decode/exec/mem/writeback control FSM with memory-wait timeout
module ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned OPC_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_IR,
  input  logic        in_Z,
  input  logic        in_MEM_RDY,
  output logic        S_MXSE,
  output logic        S_MXWB,
  output logic        S_PC,
  output logic        W_PC,
  output logic        W_IR,
  output logic        W_RF,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [3:0]  ALU_OP,
  output logic [2:0]  out_STATE,
  output logic        out_HALT,
  output logic        out_ERR
);

  state_e           state_q, state_d;
  logic [OPC_W-1:0] opc;
  logic             wait_expired;
  logic             wait_clear;
  logic             wait_en;
  logic             unused_ir;

  assign opc       = in_IR[31 -: OPC_W];
  assign unused_ir = ^in_IR[23:0];

  // Any state change (including into ERR) restarts the wait count.
  assign wait_clear = in_MEM_RDY || (state_d != state_q);
  assign wait_en    = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !in_MEM_RDY;

  ctrl_wait_cnt #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_cnt (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (wait_clear),
    .en_i      (wait_en),
    .expired_o (wait_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    S_MXSE    = MXSE_SE;
    S_MXWB    = 1'b0;
    S_PC      = 1'b0;
    W_PC      = 1'b0;
    W_IR      = 1'b0;
    W_RF      = 1'b0;
    MEM_REQ   = 1'b0;
    MEM_WE    = 1'b0;
    ALU_OP    = 4'h0;
    out_HALT  = 1'b0;
    out_ERR   = 1'b0;
    out_STATE = state_q;

    case (state_q)
      ST_FETCH: begin
        MEM_REQ = 1'b1;
        if (in_MEM_RDY) begin
          W_IR    = 1'b1;
          W_PC    = 1'b1;
          state_d = ST_DECODE;
        end else if (wait_expired) begin
          state_d = ST_ERR;
        end
      end
      ST_DECODE: begin
        if (opc_exec_legal(opc))  state_d = ST_EXEC;
        else if (opc == OP_HALT)  state_d = ST_HALT;
        else                      state_d = ST_ERR;
      end
      ST_EXEC: begin
        ALU_OP = in_IR[27:24];
        case (opc)
          OP_ALUR: begin S_MXSE = MXSE_RB; state_d = ST_WB;  end
          OP_ALUI: begin S_MXSE = MXSE_SE; state_d = ST_WB;  end
          OP_LD,
          OP_ST:   begin S_MXSE = MXSE_SE; state_d = ST_MEM; end
          OP_JMP:  begin W_PC = 1'b1; S_PC = 1'b1; state_d = ST_FETCH; end
          OP_BEQ: begin
            S_MXSE  = MXSE_RB;
            W_PC    = in_Z;
            S_PC    = in_Z;
            state_d = ST_FETCH;
          end
          default: state_d = ST_ERR;
        endcase
      end
      ST_MEM: begin
        MEM_REQ = 1'b1;
        MEM_WE  = (opc == OP_ST);
        S_MXSE  = MXSE_SE;
        if (in_MEM_RDY) begin
          state_d = (opc == OP_LD) ? ST_WB : ST_FETCH;
        end else if (wait_expired) begin
          state_d = ST_ERR;
        end
      end
      ST_WB: begin
        W_RF    = 1'b1;
        S_MXWB  = (opc == OP_LD);
        state_d = ST_FETCH;
      end
      ST_HALT: out_HALT = 1'b1;
      ST_ERR:  out_ERR  = 1'b1;
      default: state_d = ST_ERR;
    endcase

    // Reset cycle aborts whatever is in flight: nothing may be strobed.
    if (reset) begin
      S_MXSE    = 1'b0;
      S_MXWB    = 1'b0;
      S_PC      = 1'b0;
      W_PC      = 1'b0;
      W_IR      = 1'b0;
      W_RF      = 1'b0;
      MEM_REQ   = 1'b0;
      MEM_WE    = 1'b0;
      ALU_OP    = 4'h0;
      out_STATE = 3'd0;
      out_HALT  = 1'b0;
      out_ERR   = 1'b0;
    end
  end

endmodule

// File: tb/tb_ctrl_unit.sv
// tb/tb_ctrl_unit.sv - scoreboard bench for ctrl_unit driven by hand-computed per-cycle vectors
module tb_ctrl_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_IR;
  logic        in_Z;
  logic        in_MEM_RDY;
  logic        S_MXSE, S_MXWB, S_PC, W_PC, W_IR, W_RF, MEM_REQ, MEM_WE;
  logic [3:0]  ALU_OP;
  logic [2:0]  out_STATE;
  logic        out_HALT, out_ERR;

  ctrl_unit dut (
    .clk        (clk),
    .reset      (reset),
    .in_IR      (in_IR),
    .in_Z       (in_Z),
    .in_MEM_RDY (in_MEM_RDY),
    .S_MXSE     (S_MXSE),
    .S_MXWB     (S_MXWB),
    .S_PC       (S_PC),
    .W_PC       (W_PC),
    .W_IR       (W_IR),
    .W_RF       (W_RF),
    .MEM_REQ    (MEM_REQ),
    .MEM_WE     (MEM_WE),
    .ALU_OP     (ALU_OP),
    .out_STATE  (out_STATE),
    .out_HALT   (out_HALT),
    .out_ERR    (out_ERR)
  );

  always #5 clk = ~clk;

  localparam logic [16:0] MXSE = 17'h1_0000;
  localparam logic [16:0] MXWB = 17'h0_8000;
  localparam logic [16:0] SPC  = 17'h0_4000;
  localparam logic [16:0] WPC  = 17'h0_2000;
  localparam logic [16:0] WIR  = 17'h0_1000;
  localparam logic [16:0] WRF  = 17'h0_0800;
  localparam logic [16:0] REQ  = 17'h0_0400;
  localparam logic [16:0] WE   = 17'h0_0200;
  localparam logic [16:0] HLT  = 17'h0_0002;
  localparam logic [16:0] ERR  = 17'h0_0001;
  localparam logic [16:0] NONE = 17'h0_0000;

  localparam logic [2:0] SF = 3'd0, SD = 3'd1, SE = 3'd2, SM = 3'd3, SW = 3'd4, SH = 3'd5, SR = 3'd6;

  typedef struct {
    string       name;
    logic [16:0] v;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [16:0] got;

  assign got = {S_MXSE, S_MXWB, S_PC, W_PC, W_IR, W_RF, MEM_REQ, MEM_WE,
                ALU_OP, out_STATE, out_HALT, out_ERR};

  function automatic logic [16:0] ev(input logic [2:0] st, input logic [3:0] aop, input logic [16:0] fl);
    return fl | {8'd0, aop, st, 2'b00};
  endfunction

  task automatic cyc(input string nm, input logic rst, input logic [31:0] ir,
                     input logic z, input logic rdy, input logic [16:0] e);
    exp_t item;
    reset      = rst;
    in_IR      = ir;
    in_Z       = z;
    in_MEM_RDY = rdy;
    item.name  = nm;
    item.v     = e;
    sb_q.push_back(item);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (got !== e.v) begin
          failures++;
          $display("FAIL %s: got=%05h expected=%05h", e.name, got, e.v);
        end
      end
    end
  end

  initial begin : stimulus
    reset      = 1'b1;
    in_IR      = 32'h0;
    in_Z       = 1'b0;
    in_MEM_RDY = 1'b1;
    @(posedge clk);
    #1;

    cyc("reset0", 1, 32'h0, 0, 1, NONE);
    cyc("reset1", 1, 32'h0, 0, 1, NONE);

    cyc("alui_fetch", 0, 32'h1300_0000, 0, 1, ev(SF, 4'h0, REQ | WIR | WPC));
    cyc("alui_dec",   0, 32'h1300_0000, 0, 1, ev(SD, 4'h0, NONE));
    cyc("alui_exec",  0, 32'h1300_0000, 0, 1, ev(SE, 4'h3, NONE));
    cyc("alui_wb",    0, 32'h1300_0000, 0, 1, ev(SW, 4'h0, WRF));

    cyc("alur_fetch", 0, 32'h0300_0000, 0, 1, ev(SF, 4'h0, REQ | WIR | WPC));
    cyc("alur_dec",   0, 32'h0300_0000, 0, 1, ev(SD, 4'h0, NONE));
    cyc("alur_exec",  0, 32'h0300_0000, 0, 1, ev(SE, 4'h3, MXSE));
    cyc("alur_wb",    0, 32'h0300_0000, 0, 1, ev(SW, 4'h0, WRF));

    cyc("ld_fetch",   0, 32'h2000_0004, 0, 1, ev(SF, 4'h0, REQ | WIR | WPC));
    cyc("ld_dec",     0, 32'h2000_0004, 0, 1, ev(SD, 4'h0, NONE));
    cyc("ld_exec",    0, 32'h2000_0004, 0, 1, ev(SE, 4'h0, NONE));
    for (int i = 0; i < 3; i++)
      cyc("ld_mem_wait", 0, 32'h2000_0004, 0, 0, ev(SM, 4'h0, REQ));
    cyc("ld_mem_rdy", 0, 32'h2000_0004, 0, 1, ev(SM, 4'h0, REQ));
    cyc("ld_wb",      0, 32'h2000_0004, 0, 1, ev(SW, 4'h0, WRF | MXWB));

    cyc("st_fetch",   0, 32'h3000_0008, 0, 1, ev(SF, 4'h0, REQ | WIR | WPC));
    cyc("st_dec",     0, 32'h3000_0008, 0, 1, ev(SD, 4'h0, NONE));
    cyc("st_exec",    0, 32'h3000_0008, 0, 1, ev(SE, 4'h0, NONE));
    cyc("st_mem",     0, 32'h3000_0008, 0, 1, ev(SM, 4'h0, REQ | WE));

    cyc("beq1_fetch", 0, 32'h5000_0010, 1, 1, ev(SF, 4'h0, REQ | WIR | WPC));
    cyc("beq1_dec",   0, 32'h5000_0010, 1, 1, ev(SD, 4'h0, NONE));
    cyc("beq1_exec",  0, 32'h5000_0010, 1, 1, ev(SE, 4'h0, MXSE | WPC | SPC));
    cyc("beq0_fetch", 0, 32'h5000_0010, 0, 1, ev(SF, 4'h0, REQ | WIR | WPC));
    cyc("beq0_dec",   0, 32'h5000_0010, 0, 1, ev(SD, 4'h0, NONE));
    cyc("beq0_exec",  0, 32'h5000_0010, 0, 1, ev(SE, 4'h0, MXSE));

    cyc("jmp_abort_fetch", 0, 32'h4000_0000, 0, 1, ev(SF, 4'h0, REQ | WIR | WPC));
    cyc("jmp_abort_dec",   0, 32'h4000_0000, 0, 1, ev(SD, 4'h0, NONE));
    cyc("jmp_abort_rst",   1, 32'h4000_0000, 0, 1, NONE);
    cyc("jmp_fetch",       0, 32'h4000_0000, 0, 1, ev(SF, 4'h0, REQ | WIR | WPC));
    cyc("jmp_dec",         0, 32'h4000_0000, 0, 1, ev(SD, 4'h0, NONE));
    cyc("jmp_exec",        0, 32'h4000_0000, 0, 1, ev(SE, 4'h0, WPC | SPC));

    for (int i = 0; i < 15; i++)
      cyc("rdywins_wait", 0, 32'hF000_0000, 0, 0, ev(SF, 4'h0, REQ));
    cyc("rdywins_fetch", 0, 32'hF000_0000, 0, 1, ev(SF, 4'h0, REQ | WIR | WPC));
    cyc("halt_dec",      0, 32'hF000_0000, 0, 1, ev(SD, 4'h0, NONE));
    cyc("halt0",         0, 32'hF000_0000, 0, 1, ev(SH, 4'h0, HLT));
    cyc("halt1",         0, 32'hF000_0000, 0, 1, ev(SH, 4'h0, HLT));
    cyc("halt_rst",      1, 32'hF000_0000, 0, 1, NONE);

    for (int i = 0; i < 16; i++)
      cyc("tmo_wait", 0, 32'h1300_0000, 0, 0, ev(SF, 4'h0, REQ));
    for (int i = 0; i < 3; i++)
      cyc("tmo_err", 0, 32'h1300_0000, 0, 1, ev(SR, 4'h0, ERR));
    cyc("tmo_rst", 1, 32'h1300_0000, 0, 1, NONE);

    cyc("ill_fetch", 0, 32'h7000_0000, 0, 1, ev(SF, 4'h0, REQ | WIR | WPC));
    cyc("ill_dec",   0, 32'h7000_0000, 0, 1, ev(SD, 4'h0, NONE));
    cyc("ill_err",   0, 32'h7000_0000, 0, 1, ev(SR, 4'h0, ERR));
    cyc("ill_hold",  0, 32'h7000_0000, 0, 1, ev(SR, 4'h0, ERR));
    cyc("ill_rst",   1, 32'h7000_0000, 0, 1, NONE);
    cyc("post_rst",  0, 32'h7000_0000, 0, 0, ev(SF, 4'h0, REQ));

    for (int i = 0; i < 4 && sb_q.size() > 0; i++)
      @(negedge clk);
    if (sb_q.size() > 0) begin
      failures++;
      $display("FAIL scoreboard_drain: pending=%0d required=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
